// File: rtl/fir_filter_seq.sv
// Time-multiplexed unsigned FIR: one MAC walks TAPS coefficients per accepted sample.
// Define FIR_SAT_EN to saturate the output; otherwise the low OUT_W bits wrap.
module fir_filter_seq #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 7,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              w_en_n,
  input  logic [7:0]        addr,
  input  logic [COEF_W-1:0] p,
  input  logic              x_valid_n,
  input  logic [DATA_W-1:0] x,
  output logic              x_ready,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              busy
);
  localparam int KW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state_q, state_d;

  logic [TAPS-1:0][COEF_W-1:0] coef_q;
  logic [TAPS-1:0][DATA_W-1:0] xarr_q;
  logic [DATA_W-1:0]           mask_q;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [KW-1:0]               k_q, k_d;
  logic [OUT_W-1:0]            y_q, y_d;
  logic                        pend_vld_q;
  logic [7:0]                  pend_addr_q;
  logic [COEF_W-1:0]           pend_data_q;

  logic              wr_in, wr_act, clr, accept, last_tap;
  logic [7:0]        wr_addr;
  logic [COEF_W-1:0] wr_data;
  logic [DATA_W-1:0] p_mask;
  logic [PW-1:0]     prod;
  logic [ACC_W-1:0]  acc_sum, shifted;
  logic [OUT_W-1:0]  y_fmt;

  assign wr_in = !w_en_n;

  // Writes land directly in IDLE; while busy they wait in the pending slot,
  // which is released on the DONE->IDLE edge (a write arriving in DONE is newest).
  always_comb begin
    wr_act  = 1'b0;
    wr_addr = addr;
    wr_data = p;
    case (state_q)
      IDLE: wr_act = wr_in;
      DONE: begin
        if (wr_in) begin
          wr_act = 1'b1;
        end else if (pend_vld_q) begin
          wr_act  = 1'b1;
          wr_addr = pend_addr_q;
          wr_data = pend_data_q;
        end
      end
      default: ;
    endcase
  end

  assign p_mask   = DATA_W'(wr_data);
  assign clr      = wr_act && (wr_addr == 8'(TAPS + 1)) && wr_data[0];
  assign accept   = (state_q == IDLE) && !x_valid_n && !clr;
  assign last_tap = (k_q == KW'(TAPS - 1));

  assign prod    = {{COEF_W{1'b0}}, xarr_q[k_q]} * {{DATA_W{1'b0}}, coef_q[k_q]};
  assign acc_sum = acc_q + {{(ACC_W - PW){1'b0}}, prod};
  assign shifted = acc_sum >> SHIFT;

  generate
    if (OUT_W >= ACC_W) begin : g_wide
      assign y_fmt = OUT_W'(shifted);
    end else begin : g_narrow
`ifdef FIR_SAT_EN
      assign y_fmt = (|shifted[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
`else
      assign y_fmt = shifted[OUT_W-1:0];
`endif
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clock) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (last_tap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    x_ready = (state_q == IDLE);
    busy    = (state_q != IDLE);
    y_valid = (state_q == DONE);
  end

  // The final product is folded in combinationally so y is ready in DONE.
  always_comb begin
    acc_d = acc_q;
    k_d   = k_q;
    y_d   = y_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = '0;
          k_d   = '0;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + KW'(1);
        if (last_tap) y_d = y_fmt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      acc_q <= '0;
      k_q   <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      k_q   <= k_d;
      y_q   <= y_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      coef_q      <= '0;
      mask_q      <= '1;
      xarr_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (wr_act && (wr_addr == 8'(i))) coef_q[i] <= wr_data;
      end
      if (wr_act && (wr_addr == 8'(TAPS))) mask_q <= p_mask;
      if (clr)         xarr_q <= '0;
      else if (accept) xarr_q <= {xarr_q[TAPS-2:0], x & mask_q};
      if (state_q == MAC && wr_in) begin
        pend_vld_q  <= 1'b1;
        pend_addr_q <= addr;
        pend_data_q <= p;
      end else if (state_q == DONE) begin
        pend_vld_q  <= 1'b0;
      end
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fir_filter_seq.sv
// Scoreboard bench for fir_filter_seq: driver feeds a reference model, monitor checks y on y_valid.
module tb_fir_filter_seq;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 7;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 0;

  logic              clock = 1'b0;
  logic              rst = 1'b1;
  logic              w_en_n = 1'b1;
  logic [7:0]        addr = '0;
  logic [COEF_W-1:0] p = '0;
  logic              x_valid_n = 1'b1;
  logic [DATA_W-1:0] x = '0;
  logic              x_ready, y_valid, busy;
  logic [OUT_W-1:0]  y;

  fir_filter_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clock(clock), .rst(rst), .w_en_n(w_en_n), .addr(addr), .p(p),
    .x_valid_n(x_valid_n), .x(x), .x_ready(x_ready), .y(y), .y_valid(y_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int yv; int at; } exp_t;
  exp_t sb[$];

  // Reference model state
  int m_coef[TAPS];
  int m_line[TAPS];
  int m_mask;
  bit m_pv;
  int m_pa, m_pd;
  int free_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_coef[i] = 0;
      m_line[i] = 0;
    end
    m_mask = (1 << DATA_W) - 1;
    m_pv = 1'b0;
  endfunction

  function automatic void m_write(input int a, input int d);
    if (a < TAPS) m_coef[a] = d;
    else if (a == TAPS) m_mask = d & ((1 << DATA_W) - 1);
    else if (a == TAPS + 1 && (d & 1) == 1)
      for (int i = 0; i < TAPS; i++) m_line[i] = 0;
  endfunction

  function automatic int m_expect();
    longint acc = 0;
    longint maxv = (longint'(1) << OUT_W) - 1;
    for (int i = 0; i < TAPS; i++) acc += longint'(m_line[i]) * longint'(m_coef[i]);
    acc = acc >> SHIFT;
`ifdef FIR_SAT_EN
    if (acc > maxv) acc = maxv;
`else
    acc = acc % (maxv + 1);
`endif
    return int'(acc);
  endfunction

  // One clock cycle of stimulus; the model decides what the DUT must do with it.
  task automatic step(input bit vx, input int xv, input bit vw, input int wa, input int wd, input bit r);
    int  cur;
    bit  idle, done_cyc, clr;
    int  xs;
    cur      = cyc;
    idle     = (cur >= free_cyc);
    done_cyc = (cur == free_cyc - 1);
    x_valid_n = !vx;
    x         = DATA_W'(xv);
    w_en_n    = !vw;
    addr      = 8'(wa);
    p         = COEF_W'(wd);
    rst       = r;
    chk("x_ready", 32'(x_ready), 32'(idle));
    chk("busy", 32'(busy), 32'(!idle));
    if (r) begin
      m_reset();
      free_cyc = cur + 1;
      while (sb.size() > 0 && sb[$].at > cur) void'(sb.pop_back());
    end else if (idle) begin
      clr = 1'b0;
      xs  = xv & m_mask;
      if (vw) begin
        clr = (wa == TAPS + 1) && ((wd & 1) == 1);
        m_write(wa, wd);
      end
      if (vx && !clr) begin
        for (int i = TAPS - 1; i > 0; i--) m_line[i] = m_line[i-1];
        m_line[0] = xs;
        sb.push_back('{m_expect(), cur + TAPS + 1});
        free_cyc = cur + TAPS + 2;
      end
    end else if (done_cyc) begin
      if (vw) m_write(wa, wd);
      else if (m_pv) m_write(m_pa, m_pd);
      m_pv = 1'b0;
    end else if (vw) begin
      m_pv = 1'b1;
      m_pa = wa;
      m_pd = wd;
    end
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle1();            step(0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int a, input int d); step(0, 0, 1, a, d, 0); endtask
  task automatic smp(input int v);   step(1, v, 0, 0, 0, 0); endtask
  task automatic wait_idle();
    while (cyc < free_cyc) idle1();
  endtask
  task automatic feed(input int v);  smp(v); wait_idle(); endtask
  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    chk("rst_y", 32'(y), 0);
    chk("rst_y_valid", 32'(y_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x_ready", 32'(x_ready), 1);
  endtask

  // Monitor: every y_valid pulse must match the oldest expected result, on time.
  always @(negedge clock) begin
    if (y_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_y_valid: got y=%0d with no result expected (cycle %0d)", y, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y", 32'(y), e.yv);
        chk("y_valid_cycle", cyc, e.at);
      end
    end else if (sb.size() > 0 && sb[0].at < cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_y_valid: got none expected y=%0d at cycle %0d", e.yv, e.at);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    chk("init_y", 32'(y), 0);
    chk("init_x_ready", 32'(x_ready), 1);

    // Impulse response
    for (int k = 0; k < TAPS; k++) wr(k, k + 1);
    feed(1);
    for (int k = 0; k < TAPS; k++) feed(0);

    // Saturation / wrap
    do_reset();
    for (int k = 0; k < TAPS; k++) wr(k, 255);
    feed(255);
    feed(255);

    // Masking
    do_reset();
    wr(TAPS, 8'h0F);
    wr(0, 1);
    feed(8'hFF);
    wr(TAPS, 8'hFF);
    feed(8'hFF);

    // Deferred write lands after the in-flight result
    do_reset();
    wr(0, 2);
    smp(3);
    idle1();
    idle1();
    wr(0, 5);
    wait_idle();
    feed(1);

    // Reset in the middle of MAC, then coefficients must read back as zero
    for (int k = 0; k < TAPS; k++) wr(k, k + 3);
    smp(5);
    idle1();
    idle1();
    idle1();
    do_reset();
    feed(1);
    for (int k = 0; k < TAPS; k++) feed(0);

    // Clear the delay line; a clear racing an accept drops the sample
    for (int k = 0; k < TAPS; k++) wr(k, 1);
    for (int k = 0; k < TAPS; k++) feed(10);
    wr(TAPS + 1, 1);
    feed(1);
    for (int k = 0; k < TAPS; k++) feed(10);
    step(1, 9, 1, TAPS + 1, 1, 0);
    feed(2);
    smp(4);
    wr(TAPS + 1, 1);
    wait_idle();
    feed(3);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit vx, vw, r;
      vx = ($urandom_range(0, 1) == 1);
      vw = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 149) == 0);
      step(vx, int'($urandom_range(0, 255)), vw, int'($urandom_range(0, TAPS + 3)),
           int'($urandom_range(0, 255)), r);
    end

    wait_idle();
    repeat (3) idle1();
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_filter_seq.md
Name: fir_filter_seq

Overview:
Parametrised, time-multiplexed FIR filter and the successor to the fixed 7-tap 8-bit filter. A single multiplier-accumulator walks TAPS coefficients per sample, so area stays flat as TAPS grows. Coefficients, input mask and a control register are written over the same byte-wide CPU config port as before. Samples enter and results leave through valid/ready-style handshakes.

Parameters:
DATA_W, 8, sample width in bits (unsigned)
COEF_W, 8, coefficient width in bits (unsigned); also the width of port p
TAPS, 7, number of taps, 2..64
OUT_W, 8, output width
SHIFT, 0, right shift applied to the accumulator before output
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width, derived; do not override

Ports:
clock  in  1  single clock domain, all logic on rising edge
rst  in  1  synchronous reset, active-high
w_en_n  in  1  CPU write strobe, active-low
addr  in  8  config address
p  in  COEF_W  config write data
x_valid_n  in  1  input sample valid, active-low
x  in  DATA_W  input sample
x_ready  out  1  block can accept a sample this cycle
y  out  OUT_W  filter result, held until the next result
y_valid  out  1  one-cycle pulse, y updated this cycle
busy  out  1  high while not IDLE

Behaviour:
- Address map:
  - addr 0..TAPS-1: coef[addr]
  - addr TAPS: mask, low DATA_W bits of p
  - addr TAPS+1: control; bit0=1 clears the delay line, self-clearing, no stored state
  - all other addresses: writes ignored
- Reset values: coef all 0; mask all ones; delay line 0; y=0; y_valid=0; busy=0; x_ready=1 from the first cycle after rst deasserts.
- Delay line: x_arr[0..TAPS-1], where x_arr[0] is the newest sample. A sample is accepted when x_valid_n=0 and x_ready=1. On acceptance, x_arr shifts and x_arr[0] <= x & mask.
- FSM:
  - IDLE: x_ready=1. On accept, go to MAC with k=0 and acc=0.
  - MAC: x_ready=0. acc += x_arr[k]*coef[k]; k++. After k=TAPS-1, go to DONE.
  - DONE: y <= fmt(acc>>SHIFT); y_valid=1 for this cycle only; go to IDLE.
- Timing:
  - Accept at cycle 0; y_valid at cycle TAPS+1.
  - Maximum throughput is one sample per TAPS+2 cycles.
  - x_valid_n low while x_ready=0 is ignored; the sample is not queued.
- Arithmetic: unsigned; accumulator is ACC_W wide, so it cannot overflow. fmt() is set by the optional feature below.
- Config writes in IDLE take effect at the next edge.
- Config writes while busy=1:
  - Go into a one-entry pending register (addr, data). A later write overwrites it.
  - The pending entry is applied on the DONE->IDLE edge, so the in-flight result always uses the old coefficients.
- Clear while busy: deferred the same way as other pending writes.
- A clear in IDLE coinciding with a sample accept: the clear wins and the sample is dropped.
- Reset mid-operation (any state): return to IDLE; no y_valid; pending write discarded; all registers take their reset values.

Optional Feature:
FIR_SAT_EN
- Defined: if (acc>>SHIFT) > 2^OUT_W-1, y = all ones; otherwise y = (acc>>SHIFT) exactly.
- Not defined: y = low OUT_W bits of (acc>>SHIFT), i.e. wrap-around, which matches the previous-generation filter.

Test Plan (defaults: DATA_W=8, COEF_W=8, TAPS=7, OUT_W=8, SHIFT=0):
- Impulse response: coef[k]=k+1; feed x=1, then six x=0, then one more x=0 → y sequence 1,2,3,4,5,6,7,0. Each y_valid arrives exactly 8 cycles after its accept, and x_ready is low for 8 cycles after each accept.
- Saturation: all coef=255; feed x=255 twice → second y is 255 with FIR_SAT_EN, and 2 without it (130050 mod 256).
- Masking: mask=0x0F, coef[0]=1, other coef 0; x=0xFF → y=15. Then mask=0xFF; x=0xFF → y=255.
- Deferred write: coef[0]=2; accept x=3; at MAC cycle 2, write coef[0]=5 → this y=6. Next x=1 → y = 5*1 + coef[1]*3, with coef[1]=0, so y=5.
- Reset mid-MAC: assert rst for 1 cycle at MAC cycle 3 → no y_valid; y=0; busy=0; x_ready=1 on the next cycle; all coef read back 0 via the impulse test.
- Clear: fill the delay line with x=10 seven times (coef all 1, y=70); write control bit0=1; feed x=1 → y=1.
